// File: rtl/axi_lite_write_engine.sv
// ---------------------------------------------------------------------------
// axi_lite_write_engine
//
// AXI4-Lite write master behind the PCIe-to-AXI-Lite bridge. It accepts a
// decoded memory-write request (BAR hit, PCIe address, byte enables, 32-bit
// payload). The PCIe address is translated into the AXI window of the hit
// BAR, and AW and W are then presented together. Several writes may wait for
// their B response at the same time. Their AXI addresses are queued, so a
// failing BRESP can be reported against the address that caused it. A
// watchdog flags a response that never arrives.
//
// Ports
//   m_axi_aclk, m_axi_areset   clock, synchronous active-high reset
//   m_axi_aw*                  write address channel (awprot tied 0)
//   m_axi_w*                   write data channel
//   m_axi_b*                   write response channel (bready tied 1)
//   mem_req_*                  request from the TLP decoder (valid/ready)
//   wr_outstanding             writes whose AW is done and whose B is not
//   wr_err                     1-cycle pulse: error BRESP or unmapped write dropped
//   wr_err_addr, wr_err_resp   details of the most recent error
//   wr_timeout                 sticky: no B seen for TIMEOUT_CYCLES cycles
//
// Issue FSM
//   state    | meaning
//   ST_IDLE  | slot free, may accept a request
//   ST_BOTH  | awvalid and wvalid both asserted
//   ST_AW    | W done, waiting for awready
//   ST_W     | AW done, waiting for wready
// ---------------------------------------------------------------------------
module axi_lite_write_engine #(
    parameter int          TCQ               = 1,
    parameter int          M_AXI_TDATA_WIDTH = 32,
    parameter int          M_AXI_ADDR_WIDTH  = 32,
    parameter int          MAX_OUTSTANDING   = 4,
    parameter int          TIMEOUT_CYCLES    = 1024,
    parameter logic [63:0] BAR0AXI           = 64'h0,
    parameter logic [63:0] BAR1AXI           = 64'h0,
    parameter logic [63:0] BAR2AXI           = 64'h0,
    parameter logic [63:0] BAR3AXI           = 64'h0,
    parameter logic [63:0] BAR4AXI           = 64'h0,
    parameter logic [63:0] BAR5AXI           = 64'h0,
    parameter int          BAR0SIZE          = 12,
    parameter int          BAR1SIZE          = 12,
    parameter int          BAR2SIZE          = 12,
    parameter int          BAR3SIZE          = 12,
    parameter int          BAR4SIZE          = 12,
    parameter int          BAR5SIZE          = 12
) (
    input  logic                           m_axi_aclk,
    input  logic                           m_axi_areset,

    output logic [M_AXI_ADDR_WIDTH-1:0]    m_axi_awaddr,
    output logic [2:0]                     m_axi_awprot,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,

    output logic [M_AXI_TDATA_WIDTH-1:0]   m_axi_wdata,
    output logic [M_AXI_TDATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,

    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,

    input  logic                           mem_req_valid,
    output logic                           mem_req_ready,
    input  logic [2:0]                     mem_req_bar_hit,
    input  logic [31:0]                    mem_req_pcie_address,
    input  logic [3:0]                     mem_req_byte_enable,
    input  logic                           mem_req_write_readn,
    input  logic                           mem_req_phys_func,
    input  logic [31:0]                    mem_req_write_data,

    output logic [4:0]                     wr_outstanding,
    output logic                           wr_err,
    output logic [M_AXI_ADDR_WIDTH-1:0]    wr_err_addr,
    output logic [1:0]                     wr_err_resp,
    output logic                           wr_timeout
);

    localparam int AW    = M_AXI_ADDR_WIDTH;
    localparam int DW    = M_AXI_TDATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [4:0]       MAX_CNT  = 5'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // The aperture mask keeps the PCIe offset bits; the base supplies the rest.
    localparam logic [AW-1:0] BAR0MASK = AW'((64'd1 << BAR0SIZE) - 64'd1);
    localparam logic [AW-1:0] BAR1MASK = AW'((64'd1 << BAR1SIZE) - 64'd1);
    localparam logic [AW-1:0] BAR2MASK = AW'((64'd1 << BAR2SIZE) - 64'd1);
    localparam logic [AW-1:0] BAR3MASK = AW'((64'd1 << BAR3SIZE) - 64'd1);
    localparam logic [AW-1:0] BAR4MASK = AW'((64'd1 << BAR4SIZE) - 64'd1);
    localparam logic [AW-1:0] BAR5MASK = AW'((64'd1 << BAR5SIZE) - 64'd1);
    localparam logic [AW-1:0] DW_ALIGN = ~AW'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BOTH = 2'd1,
        ST_AW   = 2'd2,
        ST_W    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [SW-1:0]     wstrb_q, wstrb_d;
    logic [4:0]        outstanding_q, outstanding_d;
    logic [AW-1:0]     fifo_q [MAX_OUTSTANDING];
    logic [AW-1:0]     fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              timeout_q, timeout_d;
    logic              err_q, err_d;
    logic [AW-1:0]     err_addr_q, err_addr_d;
    logic [1:0]        err_resp_q, err_resp_d;
    logic              drop_pend_q, drop_pend_d;
    logic [AW-1:0]     drop_addr_q, drop_addr_d;

    logic [AW-1:0]     base_sel;
    logic [AW-1:0]     mask_sel;
    logic              bar_mapped;
    logic [AW-1:0]     pcie_ext;
    logic [AW-1:0]     xlat_addr;
    logic [DW-1:0]     wdata_new;
    logic [SW-1:0]     wstrb_new;
    logic              xfer;
    logic              xfer_mapped;
    logic              xfer_drop;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              b_err;
    logic              unused_ok;

    assign unused_ok = mem_req_phys_func ^ TCQ[0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Address translation
    always_comb begin
        base_sel   = '0;
        mask_sel   = '0;
        bar_mapped = 1'b1;
        case (mem_req_bar_hit)
            3'd0:    begin base_sel = BAR0AXI[AW-1:0]; mask_sel = BAR0MASK; end
            3'd1:    begin base_sel = BAR1AXI[AW-1:0]; mask_sel = BAR1MASK; end
            3'd2:    begin base_sel = BAR2AXI[AW-1:0]; mask_sel = BAR2MASK; end
            3'd3:    begin base_sel = BAR3AXI[AW-1:0]; mask_sel = BAR3MASK; end
            3'd4:    begin base_sel = BAR4AXI[AW-1:0]; mask_sel = BAR4MASK; end
            3'd5:    begin base_sel = BAR5AXI[AW-1:0]; mask_sel = BAR5MASK; end
            default: bar_mapped = 1'b0;
        endcase
    end

    assign pcie_ext  = AW'(mem_req_pcie_address);
    assign xlat_addr = ((base_sel & ~mask_sel) | (pcie_ext & mask_sel)) & DW_ALIGN;

    // On a 64-bit bus the 32-bit payload is replicated; address bit 2 picks the lane.
    if (DW == 64) begin : g_dw64
        assign wdata_new = {mem_req_write_data, mem_req_write_data};
        assign wstrb_new = mem_req_pcie_address[2] ? {mem_req_byte_enable, 4'h0}
                                                   : {4'h0, mem_req_byte_enable};
    end else begin : g_dw32
        assign wdata_new = mem_req_write_data;
        assign wstrb_new = mem_req_byte_enable;
    end

    // A held drop report also blocks new requests, so a second drop cannot
    // overwrite the first before the first is reported.
    assign mem_req_ready = !m_axi_areset && (state_q == ST_IDLE) && !drop_pend_q &&
                           (outstanding_q < MAX_CNT);
    assign xfer        = mem_req_valid && mem_req_ready && mem_req_write_readn;
    assign xfer_mapped = xfer && bar_mapped;
    assign xfer_drop   = xfer && !bar_mapped;

    assign m_axi_awvalid = (state_q == ST_BOTH) || (state_q == ST_AW);
    assign m_axi_wvalid  = (state_q == ST_BOTH) || (state_q == ST_W);
    assign aw_hs         = m_axi_awvalid && m_axi_awready;
    assign w_hs          = m_axi_wvalid && m_axi_wready;
    // A B with nothing outstanding is spurious and is ignored entirely.
    assign b_hs          = m_axi_bvalid && (outstanding_q != 5'd0);
    assign b_err         = b_hs && (m_axi_bresp != 2'b00);

    // Issue FSM
    always_comb begin
        state_d  = state_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_mapped) begin
                    state_d  = ST_BOTH;
                    awaddr_d = xlat_addr;
                    wdata_d  = wdata_new;
                    wstrb_d  = wstrb_new;
                end
            end
            ST_BOTH: begin
                case ({aw_hs, w_hs})
                    2'b11:   state_d = ST_IDLE;
                    2'b10:   state_d = ST_W;
                    2'b01:   state_d = ST_AW;
                    default: state_d = ST_BOTH;
                endcase
            end
            ST_AW:   if (m_axi_awready) state_d = ST_IDLE;
            ST_W:    if (m_axi_wready)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outstanding count and the address queue used for error reporting
    always_comb begin
        outstanding_d = outstanding_q;
        case ({aw_hs, b_hs})
            2'b10:   outstanding_d = outstanding_q + 5'd1;
            2'b01:   outstanding_d = outstanding_q - 5'd1;
            default: outstanding_d = outstanding_q;
        endcase

        fifo_d = fifo_q;
        if (aw_hs) begin
            fifo_d[wr_ptr_q] = awaddr_q;
        end
        wr_ptr_d = aw_hs ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = b_hs  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    end

    // Response watchdog: down-counter reloaded whenever a B arrives or nothing
    // is outstanding; the timeout fires on the step from 1 to 0.
    always_comb begin
        tmr_d     = tmr_q;
        timeout_d = timeout_q;
        if (m_axi_bvalid || (outstanding_q == 5'd0)) begin
            tmr_d = TMR_LOAD;
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
            if (tmr_q == TMR_W'(1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Error reporting: a B error wins the cycle; a simultaneous drop is held
    // and reported on the following cycle.
    always_comb begin
        err_d       = 1'b0;
        err_addr_d  = err_addr_q;
        err_resp_d  = err_resp_q;
        drop_pend_d = drop_pend_q;
        drop_addr_d = drop_addr_q;
        if (b_err) begin
            err_d      = 1'b1;
            err_addr_d = fifo_q[rd_ptr_q];
            err_resp_d = m_axi_bresp;
            if (xfer_drop) begin
                drop_pend_d = 1'b1;
                drop_addr_d = pcie_ext;
            end
        end else if (drop_pend_q) begin
            err_d       = 1'b1;
            err_addr_d  = drop_addr_q;
            err_resp_d  = 2'b11;
            drop_pend_d = 1'b0;
        end else if (xfer_drop) begin
            err_d      = 1'b1;
            err_addr_d = pcie_ext;
            err_resp_d = 2'b11;
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q       <= ST_IDLE;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            outstanding_q <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            tmr_q         <= TMR_LOAD;
            timeout_q     <= 1'b0;
            err_q         <= 1'b0;
            err_addr_q    <= '0;
            err_resp_q    <= '0;
            drop_pend_q   <= 1'b0;
            drop_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            outstanding_q <= outstanding_d;
            fifo_q        <= fifo_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tmr_q         <= tmr_d;
            timeout_q     <= timeout_d;
            err_q         <= err_d;
            err_addr_q    <= err_addr_d;
            err_resp_q    <= err_resp_d;
            drop_pend_q   <= drop_pend_d;
            drop_addr_q   <= drop_addr_d;
        end
    end

    assign m_axi_awaddr   = awaddr_q;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_wdata    = wdata_q;
    assign m_axi_wstrb    = wstrb_q;
    assign m_axi_bready   = 1'b1;
    assign wr_outstanding = outstanding_q;
    assign wr_err         = err_q;
    assign wr_err_addr    = err_addr_q;
    assign wr_err_resp    = err_resp_q;
    assign wr_timeout     = timeout_q;

endmodule

// File: tb/tb_axi_lite_write_engine.sv
// ---------------------------------------------------------------------------
// Directed bench for axi_lite_write_engine. One 32-bit instance (BAR0 and
// BAR1 mapped, short timeout) covers issue, flow control, errors and the
// watchdog. One 64-bit instance covers lane steering. Inputs change on the
// falling edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_axi_lite_write_engine;

    logic        clk = 1'b0;
    logic        areset;

    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        req_valid, req_ready;
    logic [2:0]  req_bar;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic        req_wr;
    logic        req_pf;
    logic [31:0] req_data;
    logic [4:0]  outstanding;
    logic        err;
    logic [31:0] err_addr;
    logic [1:0]  err_resp;
    logic        timeout;

    logic [31:0] d64_awaddr;
    logic [2:0]  d64_awprot;
    logic        d64_awvalid;
    logic [63:0] d64_wdata;
    logic [7:0]  d64_wstrb;
    logic        d64_wvalid;
    logic        d64_bready;
    logic        d64_req_valid, d64_req_ready;
    logic [2:0]  d64_req_bar;
    logic [31:0] d64_req_addr;
    logic [3:0]  d64_req_be;
    logic [31:0] d64_req_data;
    logic [4:0]  d64_outstanding;
    logic        d64_err;
    logic [31:0] d64_err_addr;
    logic [1:0]  d64_err_resp;
    logic        d64_timeout;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_lite_write_engine #(
        .M_AXI_TDATA_WIDTH (32),
        .M_AXI_ADDR_WIDTH  (32),
        .MAX_OUTSTANDING   (4),
        .TIMEOUT_CYCLES    (16),
        .BAR0AXI           (64'h4000_0000),
        .BAR1AXI           (64'h8000_0000),
        .BAR0SIZE          (12),
        .BAR1SIZE          (16)
    ) dut (
        .m_axi_aclk           (clk),
        .m_axi_areset         (areset),
        .m_axi_awaddr         (awaddr),
        .m_axi_awprot         (awprot),
        .m_axi_awvalid        (awvalid),
        .m_axi_awready        (awready),
        .m_axi_wdata          (wdata),
        .m_axi_wstrb          (wstrb),
        .m_axi_wvalid         (wvalid),
        .m_axi_wready         (wready),
        .m_axi_bresp          (bresp),
        .m_axi_bvalid         (bvalid),
        .m_axi_bready         (bready),
        .mem_req_valid        (req_valid),
        .mem_req_ready        (req_ready),
        .mem_req_bar_hit      (req_bar),
        .mem_req_pcie_address (req_addr),
        .mem_req_byte_enable  (req_be),
        .mem_req_write_readn  (req_wr),
        .mem_req_phys_func    (req_pf),
        .mem_req_write_data   (req_data),
        .wr_outstanding       (outstanding),
        .wr_err               (err),
        .wr_err_addr          (err_addr),
        .wr_err_resp          (err_resp),
        .wr_timeout           (timeout)
    );

    axi_lite_write_engine #(
        .M_AXI_TDATA_WIDTH (64),
        .M_AXI_ADDR_WIDTH  (32),
        .MAX_OUTSTANDING   (4),
        .TIMEOUT_CYCLES    (1024),
        .BAR0AXI           (64'h4000_0000),
        .BAR0SIZE          (12)
    ) dut64 (
        .m_axi_aclk           (clk),
        .m_axi_areset         (areset),
        .m_axi_awaddr         (d64_awaddr),
        .m_axi_awprot         (d64_awprot),
        .m_axi_awvalid        (d64_awvalid),
        .m_axi_awready        (1'b1),
        .m_axi_wdata          (d64_wdata),
        .m_axi_wstrb          (d64_wstrb),
        .m_axi_wvalid         (d64_wvalid),
        .m_axi_wready         (1'b1),
        .m_axi_bresp          (2'b00),
        .m_axi_bvalid         (1'b0),
        .m_axi_bready         (d64_bready),
        .mem_req_valid        (d64_req_valid),
        .mem_req_ready        (d64_req_ready),
        .mem_req_bar_hit      (d64_req_bar),
        .mem_req_pcie_address (d64_req_addr),
        .mem_req_byte_enable  (d64_req_be),
        .mem_req_write_readn  (1'b1),
        .mem_req_phys_func    (1'b0),
        .mem_req_write_data   (d64_req_data),
        .wr_outstanding       (d64_outstanding),
        .wr_err               (d64_err),
        .wr_err_addr          (d64_err_addr),
        .wr_err_resp          (d64_err_resp),
        .wr_timeout           (d64_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Entered and left on a falling edge; reset spans two rising edges.
    task automatic do_reset();
        areset        = 1'b1;
        req_valid     = 1'b0;
        d64_req_valid = 1'b0;
        bvalid        = 1'b0;
        bresp         = 2'b00;
        awready       = 1'b1;
        wready        = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_outstanding", outstanding, 5'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_addr", err_addr, 32'h0);
        chk("rst_err_resp", err_resp, 2'b00);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_ready_low", req_ready, 1'b0);
        areset = 1'b0;
        @(negedge clk);
        chk("rst_ready_high", req_ready, 1'b1);
    endtask

    // Presents one request for a single accepted cycle; returns on the falling
    // edge after the accepting rising edge.
    task automatic send(input logic [2:0] bar, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("send_ready_wait", 1'b0, 1'b1);
        req_bar   = bar;
        req_addr  = addr;
        req_be    = be;
        req_data  = data;
        req_wr    = 1'b1;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send64(input logic [2:0] bar, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] data);
        int n = 0;
        while (!d64_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!d64_req_ready) chk("send64_ready_wait", 1'b0, 1'b1);
        d64_req_bar   = bar;
        d64_req_addr  = addr;
        d64_req_be    = be;
        d64_req_data  = data;
        d64_req_valid = 1'b1;
        @(negedge clk);
        d64_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        req_valid = 1'b0; req_bar = 3'd0; req_addr = 32'h0; req_be = 4'h0;
        req_wr = 1'b1; req_pf = 1'b0; req_data = 32'h0;
        d64_req_valid = 1'b0; d64_req_bar = 3'd0; d64_req_addr = 32'h0;
        d64_req_be = 4'h0; d64_req_data = 32'h0;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;

        // Single write through BAR0
        do_reset();
        send(3'd0, 32'h0000_1234, 4'hF, 32'hCAFE_F00D);
        chk("t1_awvalid", awvalid, 1'b1);
        chk("t1_wvalid", wvalid, 1'b1);
        chk("t1_awaddr", awaddr, 32'h4000_0234);
        chk("t1_wdata", wdata, 32'hCAFE_F00D);
        chk("t1_wstrb", wstrb, 4'hF);
        chk("t1_awprot", awprot, 3'b000);
        chk("t1_ready_busy", req_ready, 1'b0);
        @(negedge clk);
        chk("t1_outstanding1", outstanding, 5'd1);
        chk("t1_awvalid_done", awvalid, 1'b0);
        chk("t1_ready_free", req_ready, 1'b1);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        chk("t1_outstanding0", outstanding, 5'd0);
        chk("t1_no_err", err, 1'b0);
        chk("t1_bready", bready, 1'b1);

        // Four writes with B withheld fill the window; one B frees a slot
        do_reset();
        for (int i = 1; i <= 4; i++) send(3'd0, 32'(i * 16), 4'hF, 32'(i));
        @(negedge clk);
        chk("t2_outstanding4", outstanding, 5'd4);
        chk("t2_ready_full", req_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("t2_ready_still_full", req_ready, 1'b0);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        chk("t2_outstanding3", outstanding, 5'd3);
        chk("t2_ready_slot", req_ready, 1'b1);
        send(3'd0, 32'h0000_0050, 4'hF, 32'h5);
        chk("t2_fifth_awaddr", awaddr, 32'h4000_0050);
        @(negedge clk);
        chk("t2_fifth_issued", outstanding, 5'd4);

        // AW stalled: W completes alone, AW held, slot stays busy
        do_reset();
        awready = 1'b0;
        send(3'd0, 32'h0000_0ABC, 4'h3, 32'h1357_9BDF);
        @(negedge clk);
        chk("t3_wvalid_drop", wvalid, 1'b0);
        chk("t3_awvalid_held", awvalid, 1'b1);
        chk("t3_ready_wait", req_ready, 1'b0);
        repeat (3) @(negedge clk);
        chk("t3_awvalid_still", awvalid, 1'b1);
        chk("t3_outstanding0", outstanding, 5'd0);
        awready = 1'b1;
        @(negedge clk);
        chk("t3_awvalid_done", awvalid, 1'b0);
        chk("t3_ready_back", req_ready, 1'b1);
        chk("t3_outstanding1", outstanding, 5'd1);

        // Second of three writes gets SLVERR
        do_reset();
        send(3'd1, 32'h0001_A104, 4'hF, 32'hA);
        send(3'd1, 32'h0001_B208, 4'hF, 32'hB);
        send(3'd1, 32'h0001_C30C, 4'hF, 32'hC);
        @(negedge clk);
        chk("t4_outstanding3", outstanding, 5'd3);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        chk("t4_ok_no_err", err, 1'b0);
        chk("t4_outstanding2", outstanding, 5'd2);
        bresp = 2'b10;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        chk("t4_err_pulse", err, 1'b1);
        chk("t4_err_addr", err_addr, 32'h8000_B208);
        chk("t4_err_resp", err_resp, 2'b10);
        chk("t4_outstanding1", outstanding, 5'd1);
        @(negedge clk);
        chk("t4_err_one_cycle", err, 1'b0);
        chk("t4_err_addr_kept", err_addr, 32'h8000_B208);

        // Unmapped BAR write is dropped and reported
        send(3'd6, 32'h0000_5678, 4'hF, 32'hDEAD);
        chk("t5_drop_err", err, 1'b1);
        chk("t5_drop_resp", err_resp, 2'b11);
        chk("t5_drop_addr", err_addr, 32'h0000_5678);
        chk("t5_drop_no_aw", awvalid, 1'b0);
        chk("t5_drop_outstanding", outstanding, 5'd1);

        // B error and unmapped drop on the same edge: B first, drop next
        @(negedge clk);
        bvalid = 1'b1; bresp = 2'b00;
        @(negedge clk);
        bvalid = 1'b0;
        send(3'd0, 32'h0000_0070, 4'hF, 32'h7);
        @(negedge clk);
        chk("t5_coll_outstanding", outstanding, 5'd1);
        chk("t5_coll_ready", req_ready, 1'b1);
        bvalid = 1'b1; bresp = 2'b10;
        req_bar = 3'd7; req_addr = 32'h0000_9ABC; req_wr = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00; req_valid = 1'b0;
        chk("t5_coll_b_err", err, 1'b1);
        chk("t5_coll_b_resp", err_resp, 2'b10);
        chk("t5_coll_b_addr", err_addr, 32'h4000_0070);
        @(negedge clk);
        chk("t5_coll_drop_err", err, 1'b1);
        chk("t5_coll_drop_resp", err_resp, 2'b11);
        chk("t5_coll_drop_addr", err_addr, 32'h0000_9ABC);
        @(negedge clk);
        chk("t5_coll_quiet", err, 1'b0);

        // 64-bit lane steering and unmapped drop
        do_reset();
        send64(3'd0, 32'h0000_1234, 4'h3, 32'h1122_3344);
        chk("t6_awaddr", d64_awaddr, 32'h4000_0234);
        chk("t6_wstrb_hi", d64_wstrb, 8'h30);
        chk("t6_wdata", d64_wdata, 64'h1122_3344_1122_3344);
        @(negedge clk);
        send64(3'd0, 32'h0000_1230, 4'hC, 32'h5566_7788);
        chk("t6_wstrb_lo", d64_wstrb, 8'h0C);
        chk("t6_wdata_lo", d64_wdata, 64'h5566_7788_5566_7788);
        @(negedge clk);
        chk("t6_outstanding", d64_outstanding, 5'd2);
        send64(3'd6, 32'h0000_0444, 4'hF, 32'h0);
        chk("t6_drop_no_aw", d64_awvalid, 1'b0);
        chk("t6_drop_err", d64_err, 1'b1);
        chk("t6_drop_resp", d64_err_resp, 2'b11);

        // Watchdog: fires 16 edges after AW with no B, sticky, issue continues
        do_reset();
        send(3'd0, 32'h0000_0100, 4'hF, 32'h1);
        @(negedge clk);
        chk("t7_outstanding1", outstanding, 5'd1);
        repeat (15) @(negedge clk);
        chk("t7_timeout_before", timeout, 1'b0);
        @(negedge clk);
        chk("t7_timeout_set", timeout, 1'b1);
        repeat (5) @(negedge clk);
        chk("t7_timeout_sticky", timeout, 1'b1);
        send(3'd0, 32'h0000_0104, 4'hF, 32'h2);
        @(negedge clk);
        chk("t7_issue_after_timeout", outstanding, 5'd2);
        awready = 1'b0;
        send(3'd0, 32'h0000_0108, 4'hF, 32'h3);
        @(negedge clk);
        chk("t7_inflight_awvalid", awvalid, 1'b1);
        do_reset();
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        bvalid = 1'b0; bresp = 2'b00;
        chk("t7_late_b_count", outstanding, 5'd0);
        @(negedge clk);
        chk("t7_late_b_no_err", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
